// File: rtl/ser_pkg.sv
// Shared widths, default idle word and FSM state type for the serial word loader.
package ser_pkg;

    localparam int WORD_W = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

    localparam logic [WORD_W-1:0] IDLE_WORD_DEF = 4'b1010;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ser_word_loader.sv
// Serial word loader: buffers one parallel word and drives a 4:1 serializing mux
// (data/s/en). It inserts IDLE_WORD on underrun and counts completed words.
module ser_word_loader
    import ser_pkg::*;
#(
    parameter logic [WORD_W-1:0] IDLE_WORD = IDLE_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              link_en,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clr_underrun,
    output logic [WORD_W-1:0] data,
    output logic [SEL_W-1:0]  s,
    output logic              en,
    output logic              word_start,
    output logic              underrun,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam logic [SEL_W-1:0] S_LAST = '1;

    state_t            state;
    logic [WORD_W-1:0] nbuf;
    logic              nbuf_v;
    logic              load_now;
    logic              xfer;

    // Decide whether the buffered word moves into the mux register on this edge.
    always_comb begin
        load_now = 1'b0;
        if (link_en && nbuf_v) begin
            if (state == IDLE) begin
                load_now = 1'b1;
            end else if (s == S_LAST) begin
                load_now = 1'b1;
            end
        end
    end

    assign in_ready = !nbuf_v || load_now;
    assign xfer     = in_valid && in_ready;

    // One-entry next buffer: a new word may land in the same edge the old one is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nbuf   <= '0;
            nbuf_v <= 1'b0;
        end else if (xfer) begin
            nbuf   <= in_data;
            nbuf_v <= 1'b1;
        end else if (load_now) begin
            nbuf_v <= 1'b0;
        end
    end

    // Loader FSM with registered mux outputs, underrun flag and word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            data       <= '0;
            s          <= '0;
            en         <= 1'b0;
            word_start <= 1'b0;
            underrun   <= 1'b0;
            word_cnt   <= '0;
        end else begin
            word_start <= 1'b0;
            // Clear first so a same-edge underrun below overrides it.
            if (clr_underrun) begin
                underrun <= 1'b0;
            end
            case (state)
                IDLE: begin
                    en <= 1'b0;
                    s  <= '0;
                    if (link_en && nbuf_v) begin
                        data       <= nbuf;
                        en         <= 1'b1;
                        word_start <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (s != S_LAST) begin
                        s <= s + 1'b1;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        s        <= '0;
                        if (link_en) begin
                            word_start <= 1'b1;
                            if (nbuf_v) begin
                                data <= nbuf;
                            end else begin
                                data     <= IDLE_WORD;
                                underrun <= 1'b1;
                            end
                        end else begin
                            en    <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_word_loader.sv
// Self-checking bench for ser_word_loader: directed scenarios plus a randomized
// run against a transaction-level model (pending-word queue and word timing).
module tb_ser_word_loader;

    logic       clk;
    logic       rst_n;
    logic       link_en;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       clr_underrun;
    logic [3:0] data;
    logic [1:0] s;
    logic       en;
    logic       word_start;
    logic       underrun;
    logic [7:0] word_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] IDLE_W = 4'b1010;

    ser_word_loader #(.IDLE_WORD(IDLE_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .link_en     (link_en),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .clr_underrun(clr_underrun),
        .data        (data),
        .s           (s),
        .en          (en),
        .word_start  (word_start),
        .underrun    (underrun),
        .word_cnt    (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one output bundle against expected values; each field is a separate comparison.
    task automatic expect_out(input string tag, input logic [3:0] e_data, input logic [1:0] e_s,
                              input logic e_en, input logic e_ws);
        checks++;
        if (data !== e_data) begin errors++; $display("FAIL %s data: got %h want %h", tag, data, e_data); end
        checks++;
        if (s !== e_s) begin errors++; $display("FAIL %s s: got %0d want %0d", tag, s, e_s); end
        checks++;
        if (en !== e_en) begin errors++; $display("FAIL %s en: got %b want %b", tag, en, e_en); end
        checks++;
        if (word_start !== e_ws) begin errors++; $display("FAIL %s word_start: got %b want %b", tag, word_start, e_ws); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; link_en = 1'b1; in_valid = 1'b0; in_data = '0; clr_underrun = 1'b0;
        #3;
        for (int i = 0; i < 3; i++) begin
            expect_out("reset", 4'h0, 2'd0, 1'b0, 1'b0);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
            checks++;
            if (word_cnt !== 8'd0) begin errors++; $display("FAIL reset word_cnt: got %0d want 0", word_cnt); end
            checks++;
            if (underrun !== 1'b0) begin errors++; $display("FAIL reset underrun: got %b want 0", underrun); end
            step();
        end
        rst_n = 1'b1;
        step();
        expect_out("post_reset", 4'h0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_reset();
        in_valid = 1'b1; in_data = 4'h5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b ready0: got %b want 1", in_ready); end
        step();
        in_data = 4'hC;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b ready1: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        expect_out("b2b w5 s0", 4'h5, 2'd0, 1'b1, 1'b1);
        for (int k = 1; k < 4; k++) begin
            step();
            expect_out("b2b w5", 4'h5, 2'(k), 1'b1, 1'b0);
        end
        step();
        expect_out("b2b wC s0", 4'hC, 2'd0, 1'b1, 1'b1);
        link_en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            expect_out("b2b wC", 4'hC, 2'(k), 1'b1, 1'b0);
        end
        step();
        expect_out("b2b done", 4'hC, 2'd0, 1'b0, 1'b0);
        checks++;
        if (word_cnt !== 8'd2) begin errors++; $display("FAIL b2b word_cnt: got %0d want 2", word_cnt); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL b2b underrun: got %b want 0", underrun); end
        link_en = 1'b1;
    endtask

    task automatic test_underrun();
        test_reset();
        in_valid = 1'b1; in_data = 4'h3;
        step();
        in_valid = 1'b0;
        step();
        expect_out("ur w3 s0", 4'h3, 2'd0, 1'b1, 1'b1);
        step(); step(); step();
        expect_out("ur w3 s3", 4'h3, 2'd3, 1'b1, 1'b0);
        step();
        expect_out("ur idle word", IDLE_W, 2'd0, 1'b1, 1'b1);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL ur set: got %b want 1", underrun); end
        checks++;
        if (word_cnt !== 8'd1) begin errors++; $display("FAIL ur word_cnt: got %0d want 1", word_cnt); end
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur clear: got %b want 0", underrun); end
        step(); step();
        checks++;
        if (s !== 2'd3) begin errors++; $display("FAIL ur pre-collision s: got %0d want 3", s); end
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL ur set-wins: got %b want 1", underrun); end
        expect_out("ur second idle", IDLE_W, 2'd0, 1'b1, 1'b1);
    endtask

    task automatic test_link_drop();
        test_reset();
        in_valid = 1'b1; in_data = 4'h1;
        step();
        in_data = 4'h9;
        step();
        in_valid = 1'b0;
        expect_out("ld w1 s0", 4'h1, 2'd0, 1'b1, 1'b1);
        step();
        expect_out("ld w1 s1", 4'h1, 2'd1, 1'b1, 1'b0);
        link_en = 1'b0;
        step();
        expect_out("ld w1 s2", 4'h1, 2'd2, 1'b1, 1'b0);
        step();
        expect_out("ld w1 s3", 4'h1, 2'd3, 1'b1, 1'b0);
        step();
        expect_out("ld idle", 4'h1, 2'd0, 1'b0, 1'b0);
        checks++;
        if (word_cnt !== 8'd1) begin errors++; $display("FAIL ld word_cnt: got %0d want 1", word_cnt); end
        step(); step();
        expect_out("ld still idle", 4'h1, 2'd0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ld nbuf retained ready: got %b want 0", in_ready); end
        link_en = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ld resume ready: got %b want 1", in_ready); end
        step();
        expect_out("ld w9 s0", 4'h9, 2'd0, 1'b1, 1'b1);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ld underrun: got %b want 0", underrun); end
    endtask

    task automatic test_reset_midword();
        test_reset();
        in_valid = 1'b1; in_data = 4'h6;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        expect_out("rm w6 s2", 4'h6, 2'd2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rm async", 4'h0, 2'd0, 1'b0, 1'b0);
        checks++;
        if (word_cnt !== 8'd0) begin errors++; $display("FAIL rm word_cnt: got %0d want 0", word_cnt); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rm in_ready: got %b want 1", in_ready); end
        step();
        rst_n = 1'b1;
        step(); step();
        checks++;
        if (word_cnt !== 8'd0) begin errors++; $display("FAIL rm word_cnt after: got %0d want 0", word_cnt); end
        checks++;
        if (en !== 1'b0) begin errors++; $display("FAIL rm buffer discarded: en got %b want 0", en); end
    endtask

    task automatic test_wrap();
        logic [3:0] w [256];
        for (int i = 0; i < 256; i++) w[i] = 4'($urandom);
        test_reset();
        in_valid = 1'b1; in_data = w[0];
        step();
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 256; i++) begin
            expect_out("wrap s0", w[i], 2'd0, 1'b1, 1'b1);
            checks++;
            if (underrun !== 1'b0) begin errors++; $display("FAIL wrap underrun word %0d: got %b want 0", i, underrun); end
            step(); step();
            if (i < 255) begin
                in_valid = 1'b1; in_data = w[i + 1];
            end else begin
                link_en = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap ready s2 word %0d: got %b want 1", i, in_ready); end
            step();
            in_valid = 1'b0;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap ready s3 word %0d: got %b want 1", i, in_ready); end
            checks++;
            if (word_cnt !== 8'(i)) begin errors++; $display("FAIL wrap word_cnt word %0d: got %0d want %0d", i, word_cnt, 8'(i)); end
            step();
        end
        checks++;
        if (word_cnt !== 8'd0) begin errors++; $display("FAIL wrap final word_cnt: got %0d want 0", word_cnt); end
        checks++;
        if (en !== 1'b0) begin errors++; $display("FAIL wrap final en: got %b want 0", en); end
        link_en = 1'b1;
    endtask

    // Randomized run: the model holds pending words in a queue and tracks how far
    // into the current word the serializer is; link_en stays high throughout.
    task automatic test_random();
        logic [3:0] pend[$];
        logic [3:0] cur;
        bit         running;
        int         pos;
        int         sent;
        bit         ur;
        bit         ws;
        bit         want_ready;
        bit         acc;
        test_reset();
        running = 0; pos = 0; sent = 0; ur = 0; cur = 4'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 4'($urandom);
            #1;
            want_ready = (pend.size() == 0) || (!running || pos == 3);
            checks++;
            if (in_ready !== want_ready) begin errors++; $display("FAIL rand ready cyc %0d: got %b want %b", cyc, in_ready, want_ready); end
            acc = in_valid && want_ready;
            step();
            ws = 0;
            if (!running) begin
                if (pend.size() != 0) begin
                    cur = pend.pop_front(); running = 1; pos = 0; ws = 1;
                end
            end else if (pos < 3) begin
                pos++;
            end else begin
                sent++; pos = 0; ws = 1;
                if (pend.size() != 0) cur = pend.pop_front();
                else begin cur = IDLE_W; ur = 1; end
            end
            if (acc) pend.push_back(in_data);
            expect_out("rand", cur, 2'(pos), running, ws);
            checks++;
            if (underrun !== ur) begin errors++; $display("FAIL rand underrun cyc %0d: got %b want %b", cyc, underrun, ur); end
            checks++;
            if (word_cnt !== 8'(sent % 256)) begin errors++; $display("FAIL rand word_cnt cyc %0d: got %0d want %0d", cyc, word_cnt, sent % 256); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_underrun();
        test_link_drop();
        test_reset_midword();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_word_loader.md
SER_WORD_LOADER -- requirements
Module: ser_word_loader

Interface
REQ-001 Parameter: IDLE_WORD, 4'b1010, word sent on underrun.
REQ-002 Port: clk  input  1  single system clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: link_en  input  1  serial link enable; level-sensitive.
REQ-005 Port: in_data  input  4  parallel word from the word source.
REQ-006 Port: in_valid  input  1  in_data valid.
REQ-007 Port: in_ready  output  1  loader accepts in_data this cycle.
REQ-008 Port: clr_underrun  input  1  clears the underrun flag.
REQ-009 Port: data  output  4  word presented to the 4:1 serializing mux.
REQ-010 Port: s  output  2  mux select; bit index of data being sent.
REQ-011 Port: en  output  1  mux enable; high while a word is being shifted.
REQ-012 Port: word_start  output  1  high in the cycle where s==0 and en==1.
REQ-013 Port: underrun  output  1  sticky flag: IDLE_WORD was inserted.
REQ-014 Port: word_cnt  output  8  count of words fully sent; wraps 255->0.

Function
REQ-015 A transfer SHALL occur on a rising edge when in_valid and in_ready are both 1; the word goes into a one-entry next buffer (nbuf, flag nbuf_v).
REQ-016 in_ready SHALL be !nbuf_v || load_now, where load_now is 1 in any cycle where nbuf is moved into data.
REQ-017 States SHALL be IDLE and RUN; data, s, en, word_start, underrun and word_cnt SHALL all be registered.
REQ-018 IDLE: en=0, s=0. On an edge with link_en && nbuf_v: data<=nbuf, s<=0, en<=1, state<=RUN, load_now=1.
REQ-019 IDLE with link_en && !nbuf_v SHALL stay IDLE with no IDLE_WORD insertion.
REQ-020 RUN with s<3: s<=s+1, data held, en held at 1.
REQ-021 RUN with s==3: word_cnt<=word_cnt+1 (mod 256).
REQ-022 RUN with s==3, link_en=1 and nbuf_v=1: data<=nbuf, s<=0, load_now=1.
REQ-023 RUN with s==3, link_en=1 and nbuf_v=0: data<=IDLE_WORD, s<=0, underrun<=1.
REQ-024 RUN with s==3 and link_en=0: state<=IDLE, en<=0, s<=0, data held; nbuf is retained.
REQ-025 Deasserting link_en while s<3 SHALL NOT truncate the word; the current word completes first.
REQ-026 A transfer and load_now in the same cycle SHALL leave nbuf holding the new word with nbuf_v=1.
REQ-027 clr_underrun SHALL clear underrun on the next edge; if a new underrun occurs in the same cycle, set wins.
REQ-028 Latency: a word accepted at edge N into an empty loader in IDLE with link_en=1 SHALL appear at edge N+1, with en=1 and s=0.
REQ-029 Words SHALL be serialized in index order data[0], data[1], data[2], data[3]; bit order is never reversed.

Reset
REQ-030 When rst_n=0, the block SHALL set asynchronously: state=IDLE, data=0, s=0, en=0, word_start=0, underrun=0, word_cnt=0, nbuf_v=0.
REQ-031 In reset, in_ready SHALL be 1 (nbuf empty); any buffered word is discarded.
REQ-032 Reset asserted mid-word SHALL abort the word immediately, and word_cnt SHALL NOT increment.

Structure
REQ-033 The shared package ser_pkg SHALL hold WORD_W=4, SEL_W=2, CNT_W=8, the default IDLE_WORD and the state enum {IDLE, RUN}.
REQ-034 The block SHALL be a single module with no sub-module; the select counter and next buffer are too small to split.

Verification
REQ-035 The bench SHALL drive reset with link_en=1 and no valid input, and SHALL check: en=0, s=0, data=0, in_ready=1, word_cnt=0 throughout.
REQ-036 The bench SHALL push 4'h5 then 4'hC back-to-back with link_en=1, and SHALL check: data=5 with s=0..3, then data=C with s=0..3 on the next edge, no gap, word_start pulses 4 cycles apart, word_cnt=2.
REQ-037 The bench SHALL push a single 4'h3 and then starve the input, and SHALL check: after s==3, data=4'hA, underrun=1; a clr_underrun pulse on a cycle with no new underrun clears it.
REQ-038 The bench SHALL drop link_en at s==1 while nbuf holds 4'h9, and SHALL check: s runs to 3, en=0 next, state IDLE, nbuf retained; on link_en=1, data=9 the next edge.
REQ-039 The bench SHALL assert rst_n=0 mid-word at s==2, and SHALL check: outputs go to reset values with no clock edge, and word_cnt is unchanged from 0.
REQ-040 The bench SHALL stream 256 words with no gaps, and SHALL check: word_cnt wraps to 0, in_ready stays 1, underrun stays 0.
